pll_lock_monitor: RTL and testbench
===================================

Name: pll_lock_monitor

Overview:
- Parametrised lock detector and frequency meter for the on-chip PLL clock domain.
- Runs on the PLL output clock `CLK` and samples the slow `REF` input through a 2-flop synchroniser.
- Counts CLK cycles across a window of REF periods and checks the count against the expected multiplication ratio within a tolerance.
- Asserts `lock` after a run of consecutive good windows. Reports a timeout when REF stalls. Gates downstream clock enable and core release in the SoC top.

Parameters:
- DIV, 8: expected CLK cycles per REF period (PLL multiplication ratio).
- REF_WIN, 4: REF periods per measurement window.
- TOL, 2: max allowed |measured − DIV*REF_WIN|, in CLK cycles, for a good window.
- LOCK_CNT, 3: consecutive good windows needed to assert `lock`.
- UNLOCK_CNT, 2: consecutive bad windows, while locked, needed to drop `lock`.
- TIMEOUT, 64: CLK cycles without a REF rising edge that raise `err`.
- CW, 16: width of the cycle counter and `meas_count`. Must hold DIV*REF_WIN+TOL and TIMEOUT.

Ports:
- CLK  in  1  PLL output clock; sole clock.
- reset  in  1  synchronous, active-low reset; 0 resets on next CLK rising edge.
- REF  in  1  reference clock, treated as asynchronous data.
- en  in  1  monitor enable; low forces IDLE.
- lock  out  1  PLL locked indication.
- meas_valid  out  1  one-cycle pulse when a window completes.
- meas_count  out  CW  CLK cycles measured in the last completed window.
- good  out  1  result of last window (1 = within TOL); valid with/after meas_valid.
- err  out  1  sticky REF timeout flag.
- state  out  2  FSM state: 0 IDLE, 1 ALIGN, 2 MEASURE.

Behaviour:
- Reset (reset=0 at a CLK edge): all outputs 0, FSM IDLE, synchroniser flops 0, all counters 0. Reset has priority over everything; mid-window reset discards the partial window.
- REF path:
  - sync1 <= REF; sync2 <= sync1; sync3 <= sync2.
  - Rising edge `re` = sync2 & ~sync3.
  - `re` is asserted 3 CLK edges after REF rises, for exactly one cycle per REF rising edge.
- IDLE:
  - While en=0: lock=0; good/bad run counters cleared; err cleared; cyc_cnt cleared; meas_count holds its last value.
  - en=1 → ALIGN on the next cycle.
- ALIGN:
  - Waits for `re`. On `re`: cyc_cnt<=0, ref_cnt<=0, go to MEASURE.
  - cyc_cnt counts here too, for timeout purposes only.
- MEASURE:
  - cyc_cnt increments every cycle, saturating at 2^CW−1.
  - On `re`: ref_cnt increments.
  - On the `re` where ref_cnt reaches REF_WIN, the window ends:
    - measured value = cyc_cnt+1 = cycles elapsed since the start edge; ideal = DIV*REF_WIN.
    - Registered outputs on the next edge: meas_count <= measured; meas_valid <= 1 for one cycle; good <= (|measured − DIV*REF_WIN| <= TOL).
    - The end edge is also the next window's start: cyc_cnt<=0, ref_cnt<=0, no gap between windows.
- Lock logic (updated in the same cycle meas_valid is registered):
  - Good window: good_run++ (saturating at LOCK_CNT), bad_run<=0; lock<=1 when good_run reaches LOCK_CNT.
  - Bad window: bad_run++ (saturating at UNLOCK_CNT), good_run<=0; if locked and bad_run reaches UNLOCK_CNT, lock<=0.
  - While unlocked, a bad window only resets good_run.
- Timeout:
  - In ALIGN or MEASURE, if cyc_cnt reaches TIMEOUT−1 with no intervening `re`: err<=1 (sticky), lock<=0, good_run and bad_run <= 0, FSM → ALIGN, cyc_cnt<=0.
  - `err` clears only on reset or en=0.
- en=0 mid-window: next edge → IDLE with the same effects as the IDLE state. No meas_valid is issued for the partial window.
- Simultaneous events:
  - `re` and timeout in the same cycle: `re` wins, no err.
  - en falling and window end in the same cycle: en wins, no meas_valid.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with REF toggling → lock, meas_valid, meas_count, good, err, state all 0. Release with en=1 → state=1 next cycle.
2. Exact ratio (defaults): REF period 8 CLK, en=1 → meas_count=32, good=1 every 32 cycles. lock rises in the same cycle as the 3rd meas_valid; no earlier.
3. Tolerance boundary: REF windows measuring 34 → good=1; windows measuring 35 and 29 → good=0. Alternate 3×34 then 1×35 → lock=1, stays 1 (one bad window < UNLOCK_CNT=2).
4. Loss of lock: after lock=1, switch REF period to 10 → meas_count=40, good=0. lock drops with the 2nd bad meas_valid.
5. REF stall: after lock=1, hold REF=0 → err=1 and lock=0 exactly 64 cycles after the last `re`, state=1. Resume REF period 8 → re-lock after 3 windows; err stays 1 until en=0.
6. Mid-operation abort: reset=0 (and separately en=0) 20 cycles into a window → no meas_valid for that window, lock=0, state=0. Re-enable → first meas_valid only after a full aligned window.

Source files
------------

// File: rtl/pll_lock_monitor.sv
// PLL lock detector and frequency meter: counts CLK cycles across REF_WIN
// periods of a synchronised REF and qualifies lock over consecutive windows.
module pll_lock_monitor #(
    parameter int DIV        = 8,
    parameter int REF_WIN    = 4,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int TIMEOUT    = 64,
    parameter int CW         = 16
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          REF,
    input  logic          en,
    output logic          lock,
    output logic          meas_valid,
    output logic [CW-1:0] meas_count,
    output logic          good,
    output logic          err,
    output logic [1:0]    state
);

    localparam int RW = $clog2(REF_WIN + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    localparam logic [CW-1:0] IDEAL    = CW'(DIV * REF_WIN);
    localparam logic [CW-1:0] TOL_C    = CW'(TOL);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [RW-1:0] REF_LAST = RW'(REF_WIN - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [BW-1:0] BAD_MAX  = BW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALIGN   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic within_tol(input logic [CW-1:0] m);
        logic [CW-1:0] d;
        d = (m >= IDEAL) ? (m - IDEAL) : (IDEAL - m);
        within_tol = (d <= TOL_C);
    endfunction

    state_t          state_r, state_s;
    logic            sync1_r, sync2_r, sync3_r;
    logic [CW-1:0]   cyc_cnt_r, cyc_cnt_s;
    logic [CW-1:0]   gap_cnt_r, gap_cnt_s;
    logic [RW-1:0]   ref_cnt_r, ref_cnt_s;
    logic [GW-1:0]   good_run_r, good_run_s;
    logic [BW-1:0]   bad_run_r, bad_run_s;
    logic            lock_r, lock_s;
    logic            meas_valid_r, meas_valid_s;
    logic [CW-1:0]   meas_count_r, meas_count_s;
    logic            good_r, good_s;
    logic            err_r, err_s;
    logic            re_s, timeout_s, win_good_s;
    logic [CW-1:0]   measured_s;

    assign re_s       = sync2_r & ~sync3_r;
    // gap_cnt tracks time since the last REF edge; cyc_cnt only measures the window
    assign timeout_s  = (gap_cnt_r == TO_LAST);
    assign measured_s = sat_inc(cyc_cnt_r);
    assign win_good_s = within_tol(measured_s);

    // Next-state, counter and output computation
    always_comb begin
        state_s      = state_r;
        cyc_cnt_s    = cyc_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        ref_cnt_s    = ref_cnt_r;
        good_run_s   = good_run_r;
        bad_run_s    = bad_run_r;
        lock_s       = lock_r;
        meas_valid_s = 1'b0;
        meas_count_s = meas_count_r;
        good_s       = good_r;
        err_s        = err_r;
        if (!en) begin
            state_s    = ST_IDLE;
            lock_s     = 1'b0;
            good_run_s = '0;
            bad_run_s  = '0;
            err_s      = 1'b0;
            cyc_cnt_s  = '0;
            gap_cnt_s  = '0;
            ref_cnt_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s   = ST_ALIGN;
                    cyc_cnt_s = '0;
                    gap_cnt_s = '0;
                end
                ST_ALIGN: begin
                    if (re_s) begin
                        state_s   = ST_MEASURE;
                        cyc_cnt_s = '0;
                        gap_cnt_s = '0;
                        ref_cnt_s = '0;
                    end else if (timeout_s) begin
                        err_s      = 1'b1;
                        lock_s     = 1'b0;
                        good_run_s = '0;
                        bad_run_s  = '0;
                        cyc_cnt_s  = '0;
                        gap_cnt_s  = '0;
                    end else begin
                        cyc_cnt_s = sat_inc(cyc_cnt_r);
                        gap_cnt_s = sat_inc(gap_cnt_r);
                    end
                end
                ST_MEASURE: begin
                    if (re_s) begin
                        gap_cnt_s = '0;
                        if (ref_cnt_r == REF_LAST) begin
                            // Window end doubles as the next window's start edge
                            cyc_cnt_s    = '0;
                            ref_cnt_s    = '0;
                            meas_valid_s = 1'b1;
                            meas_count_s = measured_s;
                            good_s       = win_good_s;
                            if (win_good_s) begin
                                bad_run_s  = '0;
                                good_run_s = (good_run_r == GOOD_MAX) ? good_run_r
                                                                      : good_run_r + GW'(1);
                                if (good_run_s == GOOD_MAX) begin
                                    lock_s = 1'b1;
                                end else begin
                                    lock_s = lock_r;
                                end
                            end else begin
                                good_run_s = '0;
                                if (lock_r) begin
                                    bad_run_s = (bad_run_r == BAD_MAX) ? bad_run_r
                                                                       : bad_run_r + BW'(1);
                                    if (bad_run_s == BAD_MAX) begin
                                        lock_s = 1'b0;
                                    end else begin
                                        lock_s = lock_r;
                                    end
                                end else begin
                                    bad_run_s = '0;
                                end
                            end
                        end else begin
                            ref_cnt_s = ref_cnt_r + RW'(1);
                            cyc_cnt_s = sat_inc(cyc_cnt_r);
                        end
                    end else if (timeout_s) begin
                        state_s    = ST_ALIGN;
                        err_s      = 1'b1;
                        lock_s     = 1'b0;
                        good_run_s = '0;
                        bad_run_s  = '0;
                        cyc_cnt_s  = '0;
                        gap_cnt_s  = '0;
                    end else begin
                        cyc_cnt_s = sat_inc(cyc_cnt_r);
                        gap_cnt_s = sat_inc(gap_cnt_r);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, synchroniser and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            sync3_r      <= 1'b0;
            cyc_cnt_r    <= '0;
            gap_cnt_r    <= '0;
            ref_cnt_r    <= '0;
            good_run_r   <= '0;
            bad_run_r    <= '0;
            lock_r       <= 1'b0;
            meas_valid_r <= 1'b0;
            meas_count_r <= '0;
            good_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            sync1_r      <= REF;
            sync2_r      <= sync1_r;
            sync3_r      <= sync2_r;
            cyc_cnt_r    <= cyc_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            ref_cnt_r    <= ref_cnt_s;
            good_run_r   <= good_run_s;
            bad_run_r    <= bad_run_s;
            lock_r       <= lock_s;
            meas_valid_r <= meas_valid_s;
            meas_count_r <= meas_count_s;
            good_r       <= good_s;
            err_r        <= err_s;
        end
    end

    assign lock       = lock_r;
    assign meas_valid = meas_valid_r;
    assign meas_count = meas_count_r;
    assign good       = good_r;
    assign err        = err_r;
    assign state      = state_r;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomised bench for pll_lock_monitor, checked every cycle against an
// event/timestamp reference model of the monitor's behaviour.
module tb_pll_lock_monitor;

    localparam int DIV = 8, REF_WIN = 4, TOL = 2, LOCK_CNT = 3, UNLOCK_CNT = 2;
    localparam int TIMEOUT = 64, CW = 16;

    logic          CLK = 1'b0;
    logic          reset, REF, en;
    logic          lock, meas_valid, good, err;
    logic [CW-1:0] meas_count;
    logic [1:0]    state;

    int passed = 0, total = 0;

    pll_lock_monitor #(
        .DIV(DIV), .REF_WIN(REF_WIN), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .CLK(CLK), .reset(reset), .REF(REF), .en(en), .lock(lock),
        .meas_valid(meas_valid), .meas_count(meas_count), .good(good),
        .err(err), .state(state)
    );

    always #5 CLK = ~CLK;

    // Reference model: absolute edge timestamps instead of counters
    int m_state = 0, m_lock = 0, m_mv = 0, m_mc = 0, m_good = 0, m_err = 0;
    int gr = 0, br = 0, nre = 0, win_start = 0, gap_anchor = 0, edge_n = 0;
    bit ref_hist[$] = '{1'b0, 1'b0, 1'b0};   // REF level seen at previous edges, newest first

    // REF period patterns (CLK cycles); any 4 consecutive periods sum to 32/34/35/29/40/33
    int pats [6][4] = '{'{8, 8, 8, 8}, '{8, 9, 8, 9}, '{9, 9, 9, 8},
                        '{7, 7, 7, 8}, '{10, 10, 10, 10}, '{8, 8, 8, 9}};

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic do_timeout();
        m_err = 1; m_lock = 0; gr = 0; br = 0; m_state = 1; gap_anchor = edge_n;
    endtask

    task automatic model_edge();
        bit re;
        int diff;
        edge_n++;
        re = ref_hist[1] && !ref_hist[2];   // REF rose 3 edges ago -> acted on now
        ref_hist.push_front(reset ? REF : 1'b0);
        void'(ref_hist.pop_back());
        if (!reset) begin
            m_state = 0; m_lock = 0; m_mv = 0; m_mc = 0; m_good = 0; m_err = 0;
            gr = 0; br = 0; nre = 0;
            ref_hist = '{1'b0, 1'b0, 1'b0};
        end else if (!en) begin
            m_state = 0; m_lock = 0; m_mv = 0; m_err = 0; gr = 0; br = 0; nre = 0;
        end else begin
            m_mv = 0;
            case (m_state)
                0: begin m_state = 1; gap_anchor = edge_n; end
                1: begin
                    if (re) begin
                        m_state = 2; win_start = edge_n; gap_anchor = edge_n; nre = 0;
                    end else if (edge_n - gap_anchor == TIMEOUT) do_timeout();
                end
                default: begin
                    if (re) begin
                        gap_anchor = edge_n;
                        nre++;
                        if (nre == REF_WIN) begin
                            m_mc = edge_n - win_start;
                            diff = m_mc - DIV * REF_WIN;
                            if (diff < 0) diff = -diff;
                            m_good = (diff <= TOL);
                            m_mv = 1;
                            win_start = edge_n;
                            nre = 0;
                            if (m_good) begin
                                gr++; br = 0;
                                if (gr >= LOCK_CNT) m_lock = 1;
                            end else begin
                                gr = 0;
                                if (m_lock) begin
                                    br++;
                                    if (br >= UNLOCK_CNT) begin m_lock = 0; br = 0; end
                                end else br = 0;
                            end
                        end
                    end else if (edge_n - gap_anchor == TIMEOUT) do_timeout();
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("state", state, m_state);
        check("lock", lock, m_lock);
        check("meas_valid", meas_valid, m_mv);
        check("meas_count", meas_count, m_mc);
        check("good", good, m_good);
        check("err", err, m_err);
    endtask

    task automatic run_periods(input int pat, input int n);
        for (int i = 0; i < n; i++) begin
            int len;
            len = (pat < 6) ? pats[pat][i % 4] : int'($urandom_range(6, 11));
            for (int c = 0; c < len; c++) begin
                REF = (c < len / 2);
                step();
            end
        end
    endtask

    task automatic hold(input int cycles, input logic rst_v, input logic en_v);
        reset = rst_v; en = en_v; REF = 1'b0;
        for (int c = 0; c < cycles; c++) step();
        reset = 1'b1; en = 1'b1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; REF = 1'b0;
        for (int c = 0; c < 3; c++) begin REF = ~REF; step(); end
        check("reset_lock", lock, 0);
        check("reset_state", state, 0);
        reset = 1'b1; REF = 1'b0;
        step();
        check("align_after_reset", state, 1);

        run_periods(0, 24);                 // exact ratio, lock
        check("exact_lock", lock, 1);
        check("exact_count", meas_count, 32);
        run_periods(1, 16);                 // 34: still good
        check("tol34_good", good, 1);
        run_periods(2, 4);                  // 35: bad
        run_periods(4, 16);                 // 40: loss of lock
        check("ratio10_unlock", lock, 0);
        run_periods(0, 24);
        hold(90, 1'b1, 1'b1);               // REF stall
        check("stall_err", err, 1);
        check("stall_state", state, 1);
        run_periods(0, 24);
        check("relock_err_sticky", err, 1);
        hold(2, 1'b1, 1'b0);
        check("en_low_err_clear", err, 0);
        run_periods(3, 12);                 // 29: bad
        run_periods(0, 22);
        hold(1, 1'b0, 1'b1);                // mid-window reset
        run_periods(0, 22);
        hold(1, 1'b1, 1'b0);                // mid-window disable
        run_periods(0, 14);

        for (int it = 0; it < 60; it++) begin
            int act;
            run_periods($urandom_range(0, 6), $urandom_range(3, 24));
            act = $urandom_range(0, 9);
            if (act == 0) hold($urandom_range(1, 3), 1'b0, 1'b1);
            else if (act == 1) hold($urandom_range(1, 3), 1'b1, 1'b0);
            else if (act == 2) hold($urandom_range(40, 140), 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
